// File: rtl/alu.sv
// Registered 64-bit ALU: 24 operations selected by sel, one-cycle latency.
// Status flags {V,C,N,Z}; carry/overflow are meaningful only for adder-based ops.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic [4:0]  sel,
    input  logic        cin,
    output logic [63:0] result,
    output logic [3:0]  status
);

    logic [63:0]  add_x;
    logic [63:0]  add_y;
    logic         add_c;
    logic         is_arith;
    logic [64:0]  sum;
    logic [5:0]   sh;
    logic [127:0] rol_w;
    logic [127:0] ror_w;
    logic [63:0]  res_n;
    logic [3:0]   status_n;

    assign sh = B[5:0];

    // One shared adder serves ADD/ADC/SUB/SBC/INC/DEC/NEG via operand steering.
    always_comb begin
        add_x    = A;
        add_y    = B;
        add_c    = 1'b0;
        is_arith = 1'b1;
        case (sel)
            5'd4:  ;
            5'd5:  add_c = cin;
            5'd6:  begin add_y = ~B; add_c = 1'b1; end
            5'd7:  begin add_y = ~B; add_c = cin;  end
            5'd18: begin add_y = 64'd0; add_c = 1'b1; end
            5'd19: add_y = '1;
            5'd20: begin add_x = ~A; add_y = 64'd0; add_c = 1'b1; end
            default: is_arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + {64'd0, add_c};

    // Rotates taken from a doubled operand so an amount of 0 needs no special case.
    assign rol_w = {A, A} << sh;
    assign ror_w = {A, A} >> sh;

    always_comb begin
        res_n = 64'd0;
        case (sel)
            5'd0:  res_n = A & B;
            5'd1:  res_n = A | B;
            5'd2:  res_n = A ^ B;
            5'd3:  res_n = ~(A | B);
            5'd4, 5'd5, 5'd6, 5'd7,
            5'd18, 5'd19, 5'd20: res_n = sum[63:0];
            5'd8:  res_n = ~(A & B);
            5'd9:  res_n = ~(A ^ B);
            5'd10: res_n = ~A;
            5'd11: res_n = A;
            5'd12: res_n = B;
            5'd13: res_n = A << sh;
            5'd14: res_n = A >> sh;
            5'd15: res_n = $signed(A) >>> sh;
            5'd16: res_n = rol_w[127:64];
            5'd17: res_n = ror_w[63:0];
            5'd21: res_n = A * B;
            5'd22: res_n = {63'd0, $signed(A) < $signed(B)};
            5'd23: res_n = {63'd0, A < B};
            default: res_n = 64'd0;
        endcase
    end

    always_comb begin
        status_n    = 4'b0000;
        status_n[0] = (res_n == 64'd0);
        status_n[1] = res_n[63];
        if (is_arith) begin
            status_n[2] = sum[64];
            status_n[3] = (add_x[63] == add_y[63]) && (sum[63] != add_x[63]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= 64'd0;
            status <= 4'b0000;
        end else begin
            result <= res_n;
            status <= status_n;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: vector table with hand-derived expectations,
// opcode sweeps against a reference model, and a mid-cycle input-change check.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [63:0] A;
    logic [63:0] B;
    logic [4:0]  sel;
    logic        cin;
    logic [63:0] result;
    logic [3:0]  status;

    int total = 0;
    int bad   = 0;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .sel    (sel),
        .cin    (cin),
        .result (result),
        .status (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  s;
        logic        c;
        logic [63:0] er;
        logic [3:0]  es;
        string       name;
    } vec_t;

    typedef struct {
        logic [63:0] er;
        logic [3:0]  es;
        string       name;
    } exp_t;

    vec_t  vecs[$];
    exp_t  exp_q[$];
    logic  drv_valid = 1'b0;
    exp_t  drv_exp;

    // Expected values are captured at the same edge that samples the inputs.
    always @(posedge clk) begin
        if (drv_valid) exp_q.push_back(drv_exp);
    end

    // Each captured expectation is checked half a cycle later.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (result !== e.er || status !== e.es) begin
                bad++;
                $display("FAIL %s: got result=%h status=%b, want result=%h status=%b",
                         e.name, result, status, e.er, e.es);
            end
        end
    end

    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input logic [4:0] s, input logic c,
                                  output logic [63:0] r, output logic [3:0] st);
        logic [63:0] x, y;
        logic        ci;
        logic        arith;
        logic [64:0] u;
        logic [64:0] t;
        int          n;
        x = a; y = b; ci = 1'b0; arith = 1'b1;
        n = int'(b[5:0]);
        case (s)
            5'd4:  ;
            5'd5:  ci = c;
            5'd6:  begin y = ~b; ci = 1'b1; end
            5'd7:  begin y = ~b; ci = c; end
            5'd18: begin y = 64'd0; ci = 1'b1; end
            5'd19: y = {64{1'b1}};
            5'd20: begin x = ~a; y = 64'd0; ci = 1'b1; end
            default: arith = 1'b0;
        endcase
        u = {1'b0, x} + {1'b0, y} + {64'd0, ci};
        t = {x[63], x} + {y[63], y} + {64'd0, ci};
        r = 64'd0;
        case (s)
            5'd0:  r = a & b;
            5'd1:  r = a | b;
            5'd2:  r = a ^ b;
            5'd3:  r = ~(a | b);
            5'd8:  r = ~(a & b);
            5'd9:  r = ~(a ^ b);
            5'd10: r = ~a;
            5'd11: r = a;
            5'd12: r = b;
            5'd13: r = a << n;
            5'd14: r = a >> n;
            5'd15: begin
                r = a;
                for (int i = 0; i < n; i++) r = {r[63], r[63:1]};
            end
            5'd16: begin
                r = a;
                for (int i = 0; i < n; i++) r = {r[62:0], r[63]};
            end
            5'd17: begin
                r = a;
                for (int i = 0; i < n; i++) r = {r[0], r[63:1]};
            end
            5'd21: r = a * b;
            5'd22: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            5'd23: r = (a < b) ? 64'd1 : 64'd0;
            default: if (arith) r = u[63:0];
        endcase
        st = {arith ? (t[64] ^ t[63]) : 1'b0, arith ? u[64] : 1'b0, r[63], r == 64'd0};
    endfunction

    task automatic drive(input logic r, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] s, input logic c,
                         input logic [63:0] er, input logic [3:0] es, input string name);
        @(negedge clk);
        rst = r; A = a; B = b; sel = s; cin = c;
        drv_exp.er = er; drv_exp.es = es; drv_exp.name = name;
        drv_valid = 1'b1;
    endtask

    task automatic add_vec(input logic r, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] s, input logic c,
                           input logic [63:0] er, input logic [3:0] es, input string name);
        vec_t v;
        v.r = r; v.a = a; v.b = b; v.s = s; v.c = c; v.er = er; v.es = es; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] mr;
        logic [3:0]  ms;

        // status literal order is {V,C,N,Z}
        add_vec(1, 205, 512, 4, 0, 64'd0, 4'b0000, "reset");
        add_vec(0, 205, 512, 4, 0, 64'd717, 4'b0000, "add_after_reset");
        add_vec(0, 205, 512, 0, 0, 64'd0, 4'b0001, "and");
        add_vec(0, 205, 512, 1, 0, 64'd717, 4'b0000, "or");
        add_vec(0, 205, 512, 2, 0, 64'd717, 4'b0000, "xor");
        add_vec(0, 205, 512, 3, 0, 64'hFFFF_FFFF_FFFF_FD32, 4'b0010, "nor");
        add_vec(0, 205, 512, 5, 0, 64'd717, 4'b0000, "adc_cin0");
        add_vec(0, 205, 512, 5, 1, 64'd718, 4'b0000, "adc_cin1");
        add_vec(0, 205, 512, 7, 1, 64'hFFFF_FFFF_FFFF_FECD, 4'b0010, "sbc_cin1");
        add_vec(0, 205, 512, 7, 0, 64'hFFFF_FFFF_FFFF_FECC, 4'b0010, "sbc_cin0");
        add_vec(0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 4, 0, 64'h8000_0000_0000_0000, 4'b1010, "add_ovf");
        add_vec(0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 4, 1, 64'd0, 4'b0101, "add_carry");
        add_vec(0, 205, 512, 13, 0, 64'd205, 4'b0000, "lsl_0");
        add_vec(0, 205, 512, 14, 0, 64'd205, 4'b0000, "lsr_0");
        add_vec(0, 205, 512, 15, 0, 64'd205, 4'b0000, "asr_0");
        add_vec(0, 205, 512, 16, 0, 64'd205, 4'b0000, "rol_0");
        add_vec(0, 205, 512, 17, 0, 64'd205, 4'b0000, "ror_0");
        add_vec(0, 205, 4, 13, 0, 64'd3280, 4'b0000, "lsl_4");
        add_vec(0, 205, 4, 14, 0, 64'd12, 4'b0000, "lsr_4");
        add_vec(0, 205, 4, 17, 0, 64'hD000_0000_0000_000C, 4'b0010, "ror_4");
        add_vec(0, 64'h8000_0000_0000_0000, 4, 15, 0, 64'hF800_0000_0000_0000, 4'b0010, "asr_neg");
        add_vec(0, 64'h8000_0000_0000_0001, 1, 16, 0, 64'd3, 4'b0000, "rol_wrap");
        add_vec(0, 5, 5, 6, 1, 64'd0, 4'b0101, "sub_eq");
        add_vec(0, 3, 5, 6, 0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010, "sub_borrow");
        add_vec(0, 64'h8000_0000_0000_0000, 1, 6, 0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100, "sub_ovf");
        add_vec(0, 64'hFFFF_FFFF_FFFF_FFFF, 9, 18, 0, 64'd0, 4'b0101, "inc_wrap");
        add_vec(0, 0, 9, 19, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, "dec_zero");
        add_vec(0, 0, 9, 20, 0, 64'd0, 4'b0101, "neg_zero");
        add_vec(0, 64'h1_0000_0003, 64'h1_0000_0005, 21, 0, 64'h8_0000_000F, 4'b0000, "mul");
        add_vec(0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 22, 0, 64'd1, 4'b0000, "slt_neg");
        add_vec(0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 23, 0, 64'd0, 4'b0001, "sltu_big");
        add_vec(0, 205, 512, 27, 1, 64'd0, 4'b0001, "reserved");
        add_vec(1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 4, 0, 64'd0, 4'b0000, "reset_midstream");
        add_vec(0, 205, 512, 12, 0, 64'd512, 4'b0000, "passb");

        rst = 1'b1; A = '0; B = '0; sel = '0; cin = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++)
            drive(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c,
                  vecs[i].er, vecs[i].es, vecs[i].name);

        // Back-to-back opcode sweeps, once per cin value.
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 32; s++) begin
                model(64'd205, 64'd512, 5'(s), 1'(c), mr, ms);
                drive(0, 205, 512, 5'(s), 1'(c), mr, ms, $sformatf("sweep_c%0d_s%0d", c, s));
            end
        end

        // Random operands through the model.
        for (int k = 0; k < 40; k++) begin
            logic [63:0] ra, rb;
            logic [4:0]  rs;
            logic        rc;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 5'($urandom_range(0, 31));
            rc = 1'($urandom_range(0, 1));
            model(ra, rb, rs, rc, mr, ms);
            drive(0, ra, rb, rs, rc, mr, ms, $sformatf("rand_%0d_s%0d", k, rs));
        end

        // Inputs changed mid-cycle must not disturb the registered outputs.
        drive(0, 205, 512, 1, 0, 64'd717, 4'b0000, "hold_base");
        @(posedge clk);
        #2;
        A = 64'hDEAD_BEEF_0000_0001; sel = 5'd3;
        #2;
        total++;
        if (result !== 64'd717 || status !== 4'b0000) begin
            bad++;
            $display("FAIL hold: got result=%h status=%b, want result=%h status=%b",
                     result, status, 64'd717, 4'b0000);
        end

        drive(0, 205, 512, 2, 0, 64'd717, 4'b0000, "after_hold");
        @(negedge clk);
        drv_valid = 1'b0;
        repeat (3) @(negedge clk);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got pending=%0d, want pending=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
